// File: rtl/sprite_motion_if.sv
// Bus bundle for the sprite motion scheduler: frame strobe, sprite readout
// select/data and sweep status flags.
interface sprite_motion_if #(
  parameter int NUM_SPRITES = 4
);
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic             frame_tick;
  logic [SEL_W-1:0] sel;
  logic [9:0]       sprite_x;
  logic [8:0]       sprite_y;
  logic [2:0]       sprite_color;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output frame_tick, sel,
    input  sprite_x, sprite_y, sprite_color, busy, done, overrun
  );

  modport slave (
    input  frame_tick, sel,
    output sprite_x, sprite_y, sprite_color, busy, done, overrun
  );
endinterface

// File: rtl/sprite_motion_scheduler.sv
// Moves NUM_SPRITES bouncing boxes once per frame, time-sharing a single
// add/compare/clamp datapath across every sprite and both axes.
module sprite_motion_scheduler #(
  parameter int NUM_SPRITES   = 4,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BOX_WIDTH     = 100,
  parameter int BOX_HEIGHT    = 100
) (
  input  logic            clk,
  input  logic            rst,
  sprite_motion_if.slave  bus
);
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_WIDTH - BOX_WIDTH);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_HEIGHT - BOX_HEIGHT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    WRITE  = 2'd3
  } state_t;

  function automatic logic signed [10:0] reset_x(input int i);
    return 11'(32'sd50 + 32'sd100 * i);
  endfunction

  function automatic logic signed [9:0] reset_y(input int i);
    return 10'(32'sd50 + 32'sd50 * i);
  endfunction

  function automatic logic [10:0] reset_xv(input int i);
    return ((i % 2) == 0) ? 11'h002 : 11'h7FE;
  endfunction

  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == 3'b111) ? 3'b001 : c + 3'd1;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;

  logic signed [10:0] x_q  [NUM_SPRITES];
  logic signed [10:0] x_d  [NUM_SPRITES];
  logic signed [9:0]  y_q  [NUM_SPRITES];
  logic signed [9:0]  y_d  [NUM_SPRITES];
  logic [10:0]        xv_q [NUM_SPRITES];
  logic [10:0]        xv_d [NUM_SPRITES];
  logic [9:0]         yv_q [NUM_SPRITES];
  logic [9:0]         yv_d [NUM_SPRITES];
  logic [2:0]         color_q [NUM_SPRITES];
  logic [2:0]         color_d [NUM_SPRITES];

  logic [10:0]        nx_q, nx_d, nxv_q, nxv_d;
  logic [9:0]         ny_q, ny_d, nyv_q, nyv_d;
  logic               hitx_q, hitx_d, hity_q, hity_d;

  logic signed [11:0] op_a_s, op_b_s, lim_s, sum_s;
  logic [10:0]        clamp_s, new_v_s;
  logic               hit_s;

  // Shared datapath: position + velocity, edge test, clamp and bounce.
  always_comb begin
    if (state_q == STEP_Y) begin
      op_a_s = {{2{y_q[idx_q][9]}}, y_q[idx_q]};
      op_b_s = {{2{yv_q[idx_q][9]}}, yv_q[idx_q]};
      lim_s  = Y_MAX;
    end else begin
      op_a_s = {x_q[idx_q][10], x_q[idx_q]};
      op_b_s = {xv_q[idx_q][10], xv_q[idx_q]};
      lim_s  = X_MAX;
    end
    sum_s = op_a_s + op_b_s;
    hit_s = (sum_s < 12'sd0) || (sum_s >= lim_s);
    if (sum_s < 12'sd0) begin
      clamp_s = 11'd0;
    end else if (sum_s > lim_s) begin
      clamp_s = lim_s[10:0];
    end else begin
      clamp_s = sum_s[10:0];
    end
    new_v_s = hit_s ? (11'd0 - op_b_s[10:0]) : op_b_s[10:0];
  end

  // Sweep sequencing, per-axis staging and the single-cycle commit.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (bus.frame_tick & (state_q != IDLE));
    nx_d      = nx_q;
    nxv_d     = nxv_q;
    hitx_d    = hitx_q;
    ny_d      = ny_q;
    nyv_d     = nyv_q;
    hity_d    = hity_q;
    x_d       = x_q;
    y_d       = y_q;
    xv_d      = xv_q;
    yv_d      = yv_q;
    color_d   = color_q;
    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = STEP_X;
        end else begin
          state_d = IDLE;
        end
      end
      STEP_X: begin
        nx_d    = clamp_s;
        nxv_d   = new_v_s;
        hitx_d  = hit_s;
        state_d = STEP_Y;
      end
      STEP_Y: begin
        ny_d    = clamp_s[9:0];
        nyv_d   = new_v_s[9:0];
        hity_d  = hit_s;
        state_d = WRITE;
      end
      WRITE: begin
        x_d[idx_q]  = nx_q;
        y_d[idx_q]  = ny_q;
        xv_d[idx_q] = nxv_q;
        yv_d[idx_q] = nyv_q;
        if (hitx_q || hity_q) begin
          color_d[idx_q] = next_color(color_q[idx_q]);
        end else begin
          color_d[idx_q] = color_q[idx_q];
        end
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = STEP_X;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and sprite register file; reset reloads the starting layout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= {IDX_W{1'b0}};
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      nx_q      <= 11'd0;
      nxv_q     <= 11'd0;
      hitx_q    <= 1'b0;
      ny_q      <= 10'd0;
      nyv_q     <= 10'd0;
      hity_q    <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]     <= reset_x(i);
        y_q[i]     <= reset_y(i);
        xv_q[i]    <= reset_xv(i);
        yv_q[i]    <= 10'h001;
        color_q[i] <= 3'(i + 1);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      nx_q      <= nx_d;
      nxv_q     <= nxv_d;
      hitx_q    <= hitx_d;
      ny_q      <= ny_d;
      nyv_q     <= nyv_d;
      hity_q    <= hity_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xv_q      <= xv_d;
      yv_q      <= yv_d;
      color_q   <= color_d;
    end
  end

  // Readout is combinational from committed state; clamped values are non-negative.
  always_comb begin
    bus.sprite_x     = x_q[bus.sel][9:0];
    bus.sprite_y     = y_q[bus.sel][8:0];
    bus.sprite_color = color_q[bus.sel];
    bus.busy         = (state_q != IDLE);
    bus.done         = done_q;
    bus.overrun      = overrun_q;
  end
endmodule

// File: tb/tb_sprite_motion_scheduler.sv
// Randomized bench for sprite_motion_scheduler against a frame-level model
// plus directed edge-bounce, overrun and mid-sweep reset scenarios.
module tb_sprite_motion_scheduler;
  localparam int N  = 4;
  localparam int XM = 640 - 100;
  localparam int YM = 480 - 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sprite_motion_if #(.NUM_SPRITES(N)) bus ();

  sprite_motion_scheduler #(
    .NUM_SPRITES(N), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480),
    .BOX_WIDTH(100), .BOX_HEIGHT(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vectors = 0;
  int n_miscompares = 0;

  // Frame-level model: positions, velocities, colors and sweep progress.
  int px[N], py[N], vx[N], vy[N], col[N];
  int m_left = 0;
  int m_done = 0;
  int m_over = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vectors++;
    if (got != exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      px[i] = 50 + 100 * i;
      py[i] = 50 + 50 * i;
      vx[i] = (i % 2 == 0) ? 2 : -2;
      vy[i] = 1;
      col[i] = i + 1;
    end
    m_left = 0; m_done = 0; m_over = 0;
  endtask

  task automatic model_move(input int s);
    int tx, ty;
    bit hx, hy;
    tx = px[s] + vx[s];
    ty = py[s] + vy[s];
    hx = (tx < 0) || (tx >= XM);
    hy = (ty < 0) || (ty >= YM);
    px[s] = (tx < 0) ? 0 : (tx > XM) ? XM : tx;
    py[s] = (ty < 0) ? 0 : (ty > YM) ? YM : ty;
    if (hx) vx[s] = -vx[s];
    if (hy) vy[s] = -vy[s];
    if (hx || hy) col[s] = (col[s] == 7) ? 1 : col[s] + 1;
  endtask

  // A sweep takes 3 cycles per sprite; sprite k lands at the end of its 3rd.
  task automatic model_edge(input bit tick, input bit r);
    if (r) begin
      model_reset();
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        int k;
        if (tick) m_over = 1;
        k = 3 * N - m_left;
        if (k % 3 == 2) model_move(k / 3);
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (tick) begin
        m_left = 3 * N;
      end
    end
  endtask

  task automatic cycle(input bit tick, input bit r);
    int s;
    s = $urandom_range(0, N - 1);
    bus.frame_tick = tick;
    rst = r;
    bus.sel = 2'(s);
    @(posedge clk);
    model_edge(tick, r);
    #1;
    check_eq("busy", int'(bus.busy), int'(m_left > 0));
    check_eq("done", int'(bus.done), m_done);
    check_eq("overrun", int'(bus.overrun), m_over);
    check_eq("x", int'(bus.sprite_x), px[s] & 32'h3FF);
    check_eq("y", int'(bus.sprite_y), py[s] & 32'h1FF);
    check_eq("color", int'(bus.sprite_color), col[s]);
    bus.frame_tick = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_sweep();
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 3 * N; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic peek(input int s);
    bus.sel = 2'(s);
    #1;
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.sel = 2'd0;
    model_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);

    // Reset layout.
    peek(1);
    check_eq("rst_x1", int'(bus.sprite_x), 150);
    check_eq("rst_y1", int'(bus.sprite_y), 100);
    check_eq("rst_c1", int'(bus.sprite_color), 2);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_over", int'(bus.overrun), 0);

    // First sweep: busy for 12 cycles, done on the 13th.
    cycle(1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 1'b0);
      check_eq("sw_busy", int'(bus.busy), (i < 12) ? 1 : 0);
      check_eq("sw_done", int'(bus.done), (i == 12) ? 1 : 0);
    end
    peek(0);
    check_eq("sw_x0", int'(bus.sprite_x), 52);
    check_eq("sw_y0", int'(bus.sprite_y), 51);
    check_eq("sw_c0", int'(bus.sprite_color), 1);
    peek(1);
    check_eq("sw_x1", int'(bus.sprite_x), 148);
    check_eq("sw_y1", int'(bus.sprite_y), 101);
    check_eq("sw_c1", int'(bus.sprite_color), 2);

    // Left-edge bounce of sprite 1.
    for (int t = 2; t <= 75; t++) run_sweep();
    peek(1);
    check_eq("left75_x", int'(bus.sprite_x), 0);
    run_sweep();
    peek(1);
    check_eq("left76_x", int'(bus.sprite_x), 0);
    check_eq("left76_c", int'(bus.sprite_color), 3);
    run_sweep();
    peek(1);
    check_eq("left77_x", int'(bus.sprite_x), 2);

    // Right-edge bounce of sprite 0.
    for (int t = 78; t <= 244; t++) run_sweep();
    peek(0);
    check_eq("right244_x", int'(bus.sprite_x), 538);
    run_sweep();
    peek(0);
    check_eq("right245_x", int'(bus.sprite_x), 540);
    check_eq("right245_c", int'(bus.sprite_color), 2);
    run_sweep();
    peek(0);
    check_eq("right246_x", int'(bus.sprite_x), 538);

    // Overrun: a second tick mid-sweep is ignored but latched.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check_eq("ovr_set", int'(bus.overrun), 1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    peek(0);
    check_eq("ovr_x0", int'(bus.sprite_x), 52);
    check_eq("ovr_idle", int'(bus.busy), 0);
    run_sweep();
    peek(0);
    check_eq("ovr_next_x0", int'(bus.sprite_x), 54);
    check_eq("ovr_sticky", int'(bus.overrun), 1);

    // Reset during STEP_Y of sprite 2.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check_eq("mid_busy", int'(bus.busy), 0);
    for (int s = 0; s < N; s++) begin
      peek(s);
      check_eq("mid_x", int'(bus.sprite_x), 50 + 100 * s);
      check_eq("mid_y", int'(bus.sprite_y), 50 + 50 * s);
      check_eq("mid_c", int'(bus.sprite_color), s + 1);
    end
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0);
      check_eq("mid_nodone", int'(bus.done), 0);
    end

    // Random ticks, resets and readout selects against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      cycle(r < 150, r >= 992);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule

// File: doc/sprite_motion_scheduler.md
SPRITE_MOTION_SCHEDULER -- requirements
Module: sprite_motion_scheduler

Interface
REQ-001 SHALL take parameter NUM_SPRITES, default 4: number of bouncing boxes, sharing one update datapath.
REQ-002 SHALL take parameter SCREEN_WIDTH, default 640: visible width in pixels.
REQ-003 SHALL take parameter SCREEN_HEIGHT, default 480: visible height in pixels.
REQ-004 SHALL take parameter BOX_WIDTH, default 100: box width in pixels.
REQ-005 SHALL take parameter BOX_HEIGHT, default 100: box height in pixels.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse marking a new frame.
REQ-009 SHALL have port sel  input  $clog2(NUM_SPRITES)  sprite index for readout.
REQ-010 SHALL have port sprite_x  output  10  committed x of sprite sel.
REQ-011 SHALL have port sprite_y  output  9  committed y of sprite sel.
REQ-012 SHALL have port sprite_color  output  3  committed color of sprite sel.
REQ-013 SHALL have port busy  output  1  high while an update sweep is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-015 SHALL have port overrun  output  1  sticky flag: frame_tick arrived while busy.

Function
REQ-016 SHALL hold per sprite: x (11-bit signed), y (10-bit signed), xv and yv (11/10-bit two's complement), color (3-bit).
REQ-017 SHALL implement FSM IDLE, STEP_X, STEP_Y, WRITE, with sprite index idx.
REQ-018 SHALL, in IDLE with frame_tick=1, load idx=0 and go to STEP_X; otherwise stay IDLE.
REQ-019 SHALL, in STEP_X, compute tx=x+xv, hit_x = (tx<0 or tx>=SCREEN_WIDTH-BOX_WIDTH), and register clamp(tx, 0, SCREEN_WIDTH-BOX_WIDTH) and xv negated if hit_x; then go to STEP_Y.
REQ-020 SHALL, in STEP_Y, do the same for y with SCREEN_HEIGHT-BOX_HEIGHT into ty/hit_y; then go to WRITE.
REQ-021 SHALL, in WRITE, commit new x, y, xv, yv of sprite idx in one cycle; if hit_x or hit_y, color advances (111->001, else +1), exactly once even when both hit.
REQ-022 SHALL, after WRITE, go to STEP_X with idx+1, or to IDLE if idx=NUM_SPRITES-1.
REQ-023 SHALL use one shared adder/comparator path for all sprites and axes.
REQ-024 SHALL drive busy = (state != IDLE): exactly 3*NUM_SPRITES cycles per sweep (12 by default).
REQ-025 SHALL register done high for the one cycle after the last WRITE (the cycle busy first reads 0).
REQ-026 SHALL ignore frame_tick while busy, including the cycle of the last WRITE, and set overrun=1 until reset.
REQ-027 SHALL drive readout outputs combinationally from committed registers; a sprite changes only at its WRITE edge.
REQ-028 SHALL output sprite_x/sprite_y as the low 10/9 bits of the clamped non-negative x/y.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, go to IDLE with busy=0, done=0, overrun=0, regardless of sweep progress.
REQ-030 SHALL, on reset, set sprite i to x=50+100*i, y=50+50*i, xv=+2 (even i) / -2 (odd i), yv=+1, color=i+1.
REQ-031 SHALL abandon a sweep interrupted by reset without a done pulse.

Verification
REQ-032 SHALL verify reset state: after rst, sel=1 -> sprite_x=150, sprite_y=100, sprite_color=010, busy=0, done=0, overrun=0.
REQ-033 SHALL verify one sweep: tick at T -> busy=1 T+1..T+12, done=1 only at T+13; then sprite0=(52,51), sprite1=(148,101), colors unchanged.
REQ-034 SHALL verify the right-edge bounce: after 244 ticks, sprite0 x=538; tick 245 -> x=540, color 010; tick 246 -> x=538.
REQ-035 SHALL verify the left-edge bounce: after 75 ticks, sprite1 x=0; tick 76 -> x=0, color 011; tick 77 -> x=2.
REQ-036 SHALL verify overrun: second tick at T+5 -> overrun=1 persists; one sweep only, sprite0 x=52; next IDLE tick updates normally.
REQ-037 SHALL verify reset mid-sweep: rst during STEP_Y of idx=2 -> next cycle all sprites at reset values, busy=0, no done pulse.
